// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Writer side of the processor's program memory. Receives a byte stream made
// of a big-endian 16-bit instruction count N followed by N big-endian 16-bit
// instructions. Each instruction is written to program memory at consecutive
// addresses starting from 0. The processor is held in reset from the start of
// a load session until that session completes successfully.
//
// Ports:
//   clock_in            system clock, all state on the rising edge
//   reset_in            synchronous, active-low reset
//   load_in             one-cycle request to start a session (only honoured in IDLE)
//   byte_in             stream byte
//   byte_valid_in       byte_in is valid
//   byte_ready_out      loader accepts a byte (transfer on valid && ready)
//   program_address_out program memory write address
//   program_data_out    program memory write data
//   program_wr_out      program memory write strobe, one cycle per word
//   cpu_reset_out       active-high hold-in-reset for the processor
//   done_out            one-cycle pulse when a load completes
//   error_out           level: last load was rejected (bad count)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module program_loader #(
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int ADDRESS_WIDTH     = 11
) (
  input  logic                         clock_in,
  input  logic                         reset_in,
  input  logic                         load_in,
  input  logic [7:0]                   byte_in,
  input  logic                         byte_valid_in,
  output logic                         byte_ready_out,
  output logic [ADDRESS_WIDTH-1:0]     program_address_out,
  output logic [INSTRUCTION_WIDTH-1:0] program_data_out,
  output logic                         program_wr_out,
  output logic                         cpu_reset_out,
  output logic                         done_out,
  output logic                         error_out
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] COUNT_HI = 3'd1;
  localparam logic [2:0] COUNT_LO = 3'd2;
  localparam logic [2:0] INSTR_HI = 3'd3;
  localparam logic [2:0] INSTR_LO = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  logic [2:0]             state_reg;
  // Holds whichever high byte was received last: the count's or an instruction's.
  logic [7:0]             high_byte_reg;
  logic [15:0]            remaining_reg;
  // One bit wider than the address so a full-depth load can count to DEPTH
  // without aliasing back onto address 0.
  logic [ADDRESS_WIDTH:0] addr_count_reg;

  logic        take;
  logic [15:0] count_value;
  logic        count_bad;

  // Ready is a pure decode of the registered state.
  assign byte_ready_out = (state_reg == COUNT_HI) || (state_reg == COUNT_LO) ||
                          (state_reg == INSTR_HI) || (state_reg == INSTR_LO);

  assign take        = byte_valid_in && byte_ready_out;
  assign count_value = {high_byte_reg, byte_in};
  // Compared at 32 bits so a count above DEPTH is never truncated into range.
  assign count_bad   = (count_value == 16'd0) || ({16'd0, count_value} > DEPTH);

  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      state_reg           <= IDLE;
      high_byte_reg       <= 8'd0;
      remaining_reg       <= 16'd0;
      addr_count_reg      <= '0;
      program_address_out <= '0;
      program_data_out    <= '0;
      program_wr_out      <= 1'b0;
      cpu_reset_out       <= 1'b1;
      done_out            <= 1'b0;
      error_out           <= 1'b0;
    end else begin
      // Strobes default low so each is exactly one cycle wide.
      program_wr_out <= 1'b0;
      done_out       <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (load_in) begin
            state_reg      <= COUNT_HI;
            cpu_reset_out  <= 1'b1;
            error_out      <= 1'b0;
            addr_count_reg <= '0;
          end
        end

        COUNT_HI: begin
          if (take) begin
            high_byte_reg <= byte_in;
            state_reg     <= COUNT_LO;
          end
        end

        COUNT_LO: begin
          if (take) begin
            if (count_bad) begin
              // Rejected: processor stays in reset, nothing is written.
              state_reg <= IDLE;
              error_out <= 1'b1;
            end else begin
              remaining_reg <= count_value;
              state_reg     <= INSTR_HI;
            end
          end
        end

        INSTR_HI: begin
          if (take) begin
            high_byte_reg <= byte_in;
            state_reg     <= INSTR_LO;
          end
        end

        INSTR_LO: begin
          if (take) begin
            program_wr_out      <= 1'b1;
            program_data_out    <= {high_byte_reg, byte_in};
            program_address_out <= addr_count_reg[ADDRESS_WIDTH-1:0];
            addr_count_reg      <= addr_count_reg + 1'b1;
            remaining_reg       <= remaining_reg - 16'd1;
            if (remaining_reg == 16'd1) begin
              state_reg <= DONE;
            end else begin
              state_reg <= INSTR_HI;
            end
          end
        end

        DONE: begin
          done_out      <= 1'b1;
          cpu_reset_out <= 1'b0;
          state_reg     <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
`timescale 1ns/1ps

module tb_program_loader;

  localparam int AW    = 11;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          load;
  logic [7:0]    bdata;
  logic          bvalid;
  logic          ready;
  logic [AW-1:0] addr;
  logic [15:0]   data;
  logic          wr;
  logic          cpu_rst;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  program_loader #(
    .INSTRUCTION_WIDTH(16),
    .ADDRESS_WIDTH(AW)
  ) dut (
    .clock_in           (clk),
    .reset_in           (reset_n),
    .load_in            (load),
    .byte_in            (bdata),
    .byte_valid_in      (bvalid),
    .byte_ready_out     (ready),
    .program_address_out(addr),
    .program_data_out   (data),
    .program_wr_out     (wr),
    .cpu_reset_out      (cpu_rst),
    .done_out           (done),
    .error_out          (err)
  );

  int pass_count  = 0;
  int fail_count  = 0;
  int check_count = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed memory writes and completion pulses for the current session.
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  logic        wr_rst_q[$];
  int          done_cyc_q[$];
  logic        done_rst_q[$];

  always @(negedge clk) begin
    if (wr === 1'b1) begin
      wr_addr_q.push_back({21'd0, addr});
      wr_data_q.push_back({16'd0, data});
      wr_cyc_q.push_back(cyc);
      wr_rst_q.push_back(cpu_rst);
      $display("write addr=%0d data=0x%04h cycle=%0d", addr, data, cyc);
    end
    if (done === 1'b1) begin
      done_cyc_q.push_back(cyc);
      done_rst_q.push_back(cpu_rst);
      $display("done cycle=%0d cpu_reset=%0b", cyc, cpu_rst);
    end
  end

  // Reference model: the byte stream and what it should produce.
  logic [7:0]  stream[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic        exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    check_count++;
    assert (obs === expv) begin
      pass_count++;
    end else begin
      fail_count++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Count = first two bytes big-endian; valid counts are 1..DEPTH; word i is
  // bytes 2+2i (high) and 3+2i (low), written at address i.
  task automatic build_model();
    int n;
    exp_addr.delete();
    exp_data.delete();
    n = int'(stream[0]) * 256 + int'(stream[1]);
    exp_err = (n == 0) || (n > DEPTH);
    if (!exp_err) begin
      for (int i = 0; i < n; i++) begin
        exp_addr.push_back(i);
        exp_data.push_back(int'(stream[2 + 2*i]) * 256 + int'(stream[3 + 2*i]));
      end
    end
  endtask

  task automatic make_stream(input int count, input int nbytes);
    stream.delete();
    stream.push_back(8'((count >> 8) & 255));
    stream.push_back(8'(count & 255));
    for (int i = 0; i < nbytes; i++) stream.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic check_idle(input string tag, input logic exp_cpu_rst);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_wr"}, wr, 0);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_data"}, data, 0);
    check({tag, "_cpu_rst"}, cpu_rst, exp_cpu_rst);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // Called at a negedge; pulses load_in for one edge and checks the response.
  task automatic start_load(input string tag);
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    wr_rst_q.delete();
    done_cyc_q.delete();
    done_rst_q.delete();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check({tag, "_ready_after_load"}, ready, 1);
    check({tag, "_err_cleared"}, err, 0);
    check({tag, "_cpu_rst_held"}, cpu_rst, 1);
  endtask

  // mode 0: valid every cycle, 1: valid toggling 1,0,..., 2: random valid.
  // load_at: byte index at which a stray load_in pulse is injected (-1 none).
  task automatic feed(input string tag, input int mode, input int nbytes, input int load_at);
    int   idx = 0;
    int   k = 0;
    logic rdy;
    logic v;
    logic load_used = 1'b0;
    while (idx < nbytes && k < 8 * nbytes + 20) begin
      bdata = stream[idx];
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = (k % 2 == 0);
      else                v = ($urandom_range(0, 9) < 7);
      bvalid = v;
      if (idx == load_at && !load_used) begin
        load = 1'b1;
        load_used = 1'b1;
      end
      rdy = ready;
      @(posedge clk);
      if (v && rdy) idx++;
      k++;
      @(negedge clk);
      load = 1'b0;
    end
    bvalid = 1'b0;
    load = 1'b0;
    check({tag, "_bytes_accepted"}, idx, nbytes);
  endtask

  task automatic finish_and_check(input string tag, input logic strict);
    int w = 0;
    build_model();
    if (!exp_err) begin
      while (done_cyc_q.size() == 0 && w < 10) begin
        @(negedge clk);
        w++;
      end
    end
    check({tag, "_error"}, err, exp_err);
    check({tag, "_num_writes"}, wr_addr_q.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < wr_addr_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], exp_addr[i]);
      check($sformatf("%s_data%0d", tag, i), wr_data_q[i], exp_data[i]);
      check($sformatf("%s_rst_during_wr%0d", tag, i), wr_rst_q[i], 1);
      if (strict && i > 0)
        check($sformatf("%s_wr_gap%0d", tag, i), wr_cyc_q[i] - wr_cyc_q[i-1], 2);
    end
    if (!exp_err) begin
      check({tag, "_done_seen"}, done_cyc_q.size(), 1);
      if (done_cyc_q.size() > 0 && wr_cyc_q.size() > 0) begin
        check({tag, "_done_latency"}, done_cyc_q[0] - wr_cyc_q[wr_cyc_q.size()-1], 1);
        check({tag, "_cpu_rst_at_done"}, done_rst_q[0], 0);
      end
      @(negedge clk);
      @(negedge clk);
      check({tag, "_done_single"}, done_cyc_q.size(), 1);
      check({tag, "_cpu_rst_released"}, cpu_rst, 0);
      check({tag, "_ready_idle"}, ready, 0);
    end else begin
      check({tag, "_cpu_rst_after_err"}, cpu_rst, 1);
      check({tag, "_ready_after_err"}, ready, 0);
      @(negedge clk);
      check({tag, "_no_done"}, done_cyc_q.size(), 0);
      check({tag, "_err_level"}, err, 1);
    end
    $display("session %s: %0d writes, error=%0b", tag, wr_addr_q.size(), err);
  endtask

  initial begin
    reset_n = 1'b0;
    load    = 1'b0;
    bvalid  = 1'b0;
    bdata   = 8'd0;

    // Reset held: load_in pulses must be ignored.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle($sformatf("reset%0d", i), 1'b1);
      load = (i % 2 == 0);
    end
    @(negedge clk);
    load = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle($sformatf("idle%0d", i), 1'b1);
    end

    // Directed two-word load, back-to-back bytes.
    stream = '{8'h00, 8'h02, 8'h08, 8'h0D, 8'h20, 8'h02};
    start_load("dir_b2b");
    feed("dir_b2b", 0, 6, -1);
    finish_and_check("dir_b2b", 1'b1);

    // Same stream with valid toggling.
    start_load("dir_toggle");
    feed("dir_toggle", 1, 6, -1);
    finish_and_check("dir_toggle", 1'b0);

    // Zero count and DEPTH+1 count are rejected.
    stream = '{8'h00, 8'h00};
    start_load("cnt_zero");
    feed("cnt_zero", 0, 2, -1);
    finish_and_check("cnt_zero", 1'b0);

    stream = '{8'h08, 8'h01};
    start_load("cnt_2049");
    feed("cnt_2049", 0, 2, -1);
    finish_and_check("cnt_2049", 1'b0);

    // Next load clears the error.
    make_stream(3, 6);
    start_load("after_err");
    feed("after_err", 2, 8, -1);
    finish_and_check("after_err", 1'b0);

    // Full-depth load.
    make_stream(DEPTH, 2 * DEPTH);
    start_load("full");
    feed("full", 0, 2 + 2 * DEPTH, -1);
    finish_and_check("full", 1'b1);
    if (wr_addr_q.size() > 0)
      check("full_last_addr", wr_addr_q[wr_addr_q.size()-1], DEPTH - 1);

    // Stray load_in mid-session must not restart the session.
    make_stream(2, 4);
    start_load("stray_load");
    feed("stray_load", 0, 6, 3);
    finish_and_check("stray_load", 1'b1);

    // Reset after the first word of a three-word load aborts it.
    make_stream(3, 6);
    build_model();
    start_load("abort");
    feed("abort", 0, 4, -1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check_idle("abort_rst", 1'b1);
    check("abort_num_writes", wr_addr_q.size(), 1);
    if (wr_addr_q.size() > 0) begin
      check("abort_addr0", wr_addr_q[0], exp_addr[0]);
      check("abort_data0", wr_data_q[0], exp_data[0]);
    end
    @(negedge clk);
    check_idle("abort_stays_idle", 1'b1);
    check("abort_no_done", done_cyc_q.size(), 0);

    // Randomized sessions with random valid gaps.
    for (int s = 0; s < 6; s++) begin
      int n;
      n = $urandom_range(1, 8);
      make_stream(n, 2 * n);
      start_load($sformatf("rand%0d", s));
      feed($sformatf("rand%0d", s), 2, 2 + 2 * n, -1);
      finish_and_check($sformatf("rand%0d", s), 1'b0);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
